// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants shared by the sync generator and the character renderer
package vga_pkg;
  localparam int COORD_W   = 10;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: divides the system clock into a one-clk pixel-enable strobe
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] r_div;
  // free-running divider, wraps after CLK_DIV-1
  always_ff @(posedge clk or posedge reset)
    if (reset) r_div <= '0;
    else r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
  assign p_tick = (r_div == DIV_LAST);
endmodule

// File: rtl/vga_sync.sv
// vga_sync: pixel/line counters with registered hsync/vsync and combinational video_on
module vga_sync import vga_pkg::*; #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);
  localparam coord_t X_LAST = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t Y_LAST = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t HS_BEG = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_BEG = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam coord_t X_VIS  = coord_t'(H_DISPLAY);
  localparam coord_t Y_VIS  = coord_t'(V_DISPLAY);
  logic   w_tick;
  coord_t r_x, r_y, w_x_nxt, w_y_nxt;
  logic   r_hsync, r_vsync;
  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (w_tick)
  );
  // next counter values; y only moves when x wraps
  always_comb begin
    w_x_nxt = (r_x == X_LAST) ? '0 : r_x + 1'b1;
    w_y_nxt = (r_x != X_LAST) ? r_y : (r_y == Y_LAST) ? '0 : r_y + 1'b1;
  end
  // counters and syncs share one edge; syncs decode the next counts so they line up with x/y
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_tick) begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_hsync <= !(w_x_nxt >= HS_BEG && w_x_nxt <= HS_END);
      r_vsync <= !(w_y_nxt >= VS_BEG && w_y_nxt <= VS_END);
    end
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = (r_x < X_VIS) && (r_y < Y_VIS);
  assign p_tick   = w_tick;
  assign x        = r_x;
  assign y        = r_y;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: scoreboard bench comparing three vga_sync configurations against a tick-count model
module tb_vga_sync;
  typedef struct packed {
    logic       p;
    logic       hs;
    logic       vs;
    logic       vo;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic p0, hs0, vs0, vo0, p1, hs1, vs1, vo1, p2, hs2, vs2, vo2;
  logic [9:0] x0, y0, x1, y1, x2, y2;
  int n_checks = 0;
  int n_errors = 0;
  int k0 = 0;
  int k2 = 0;
  obs_t q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  vga_sync u_d4 (.clk(clk), .reset(rst_a), .hsync(hs0), .vsync(vs0), .video_on(vo0), .p_tick(p0), .x(x0), .y(y0));
  vga_sync #(.CLK_DIV(2)) u_d2 (.clk(clk), .reset(rst_a), .hsync(hs1), .vsync(vs1), .video_on(vo1), .p_tick(p1), .x(x1), .y(y1));
  vga_sync #(.CLK_DIV(2), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
             .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3))
    u_small (.clk(clk), .reset(rst_b), .hsync(hs2), .vsync(vs2), .video_on(vo2), .p_tick(p2), .x(x2), .y(y2));
  // expected outputs k clks after reset release: every CLK_DIV clks one pixel elapses
  function automatic obs_t model(input int k, d, hd, hf, hs, hb, vd, vf, vs, vb);
    obs_t m;
    int ht, vt, t, px, py;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    t  = k / d;
    px = t % ht;
    py = (t / ht) % vt;
    m.p  = (k % d) == d - 1;
    m.hs = !(px >= hd + hf && px < hd + hf + hs);
    m.vs = !(py >= vd + vf && py < vd + vf + vs);
    m.vo = (px < hd) && (py < vd);
    m.x  = 10'(px);
    m.y  = 10'(py);
    return m;
  endfunction
  function automatic obs_t small_model(input int k);
    return model(k, 2, 10, 2, 3, 2, 6, 2, 2, 3);
  endfunction
  task automatic chk(input string tag, input obs_t o, input obs_t e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s got p=%b hs=%b vs=%b vo=%b x=%0d y=%0d want p=%b hs=%b vs=%b vo=%b x=%0d y=%0d",
             tag, o.p, o.hs, o.vs, o.vo, o.x, o.y, e.p, e.hs, e.vs, e.vo, e.x, e.y);
    end
  endtask
  task automatic push_all();
    q0.push_back(model(k0, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    q1.push_back(model(k0, 2, 640, 16, 96, 48, 480, 10, 2, 33));
    q2.push_back(small_model(k2));
  endtask
  task automatic pop_all(input string tag);
    chk({tag, "_div4"}, {p0, hs0, vs0, vo0, x0, y0}, q0.pop_front());
    chk({tag, "_div2"}, {p1, hs1, vs1, vo1, x1, y1}, q1.pop_front());
    chk({tag, "_small"}, {p2, hs2, vs2, vo2, x2, y2}, q2.pop_front());
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_a) k0++;
    if (!rst_b) k2++;
    push_all();
    @(negedge clk);
    pop_all(tag);
  endtask
  initial begin
    logic found;
    obs_t e;
    repeat (2) @(negedge clk);
    push_all();
    pop_all("reset");
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (7000) step("run");
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step("seek");
      e = small_model(k2);
      found = (e.x == 10'd5) && (e.y == 10'd4);
    end
    n_checks++;
    assert (found) else begin
      n_errors++;
      $error("FAIL mid_seek got found=%b want found=1", found);
    end
    #1 rst_b = 1'b1;
    k2 = 0;
    #1 q2.push_back(small_model(0));
    chk("async_reset_small", {p2, hs2, vs2, vo2, x2, y2}, q2.pop_front());
    repeat (2) step("held");
    rst_b = 1'b0;
    repeat (600) step("after");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
